// File: rtl/pwm_duty_calc.sv
// Duty-cycle / period calculator for the PWM pulse-width detector: duty = h*SCALE/(h+l)
// via a multi-cycle restoring divider. Optional PWM_DUTY_ROUND_EN selects round-to-nearest.
module pwm_duty_calc #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SCALE  = 1000,
  parameter int unsigned DUTY_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  l_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W:0]    period,
  output logic              duty_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned N_W  = CNT_W + DUTY_W + 1;
  localparam int unsigned IT_W = $clog2(N_W);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   h_q;
  logic [CNT_W-1:0]   l_q;
  logic [CNT_W:0]     den;
  logic [CNT_W:0]     rem;
  logic [N_W-1:0]     num;
  logic [DUTY_W-1:0]  quot;
  logic [IT_W-1:0]    iter;
  logic               zero;

  logic [CNT_W:0]     den_c;
  logic [N_W-1:0]     num_c;
  logic [CNT_W+1:0]   rem_sh;
  logic               rem_ge;

  assign den_c = (CNT_W+1)'(h_q) + (CNT_W+1)'(l_q);

`ifdef PWM_DUTY_ROUND_EN
  // Adding half the divisor turns the truncating divide into round-to-nearest
  assign num_c = N_W'(h_q) * N_W'(SCALE) + N_W'(den_c >> 1);
`else
  assign num_c = N_W'(h_q) * N_W'(SCALE);
`endif

  // One restoring step: shift in next numerator MSB, subtract when it fits
  assign rem_sh = {rem, num[N_W-1]};
  assign rem_ge = (rem_sh >= {1'b0, den});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      h_q        <= '0;
      l_q        <= '0;
      den        <= '0;
      rem        <= '0;
      num        <= '0;
      quot       <= '0;
      iter       <= '0;
      zero       <= 1'b0;
      duty       <= '0;
      period     <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if ({h_cnt, l_cnt} != {h_q, l_q}) begin
            h_q   <= h_cnt;
            l_q   <= l_cnt;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          den   <= den_c;
          num   <= num_c;
          rem   <= '0;
          quot  <= '0;
          iter  <= '0;
          zero  <= (den_c == '0);
          state <= (den_c == '0) ? DONE : DIV;
        end
        DIV: begin
          rem  <= rem_ge ? (CNT_W+1)'(rem_sh - {1'b0, den}) : rem_sh[CNT_W:0];
          quot <= {quot[DUTY_W-2:0], rem_ge};
          num  <= {num[N_W-2:0], 1'b0};
          iter <= iter + IT_W'(1);
          if (iter == IT_W'(N_W - 1)) state <= DONE;
        end
        DONE: begin
          // Quotient never exceeds SCALE since h <= h+l, so no saturation
          duty       <= zero ? '0 : quot;
          period     <= den;
          err        <= zero;
          duty_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Directed table-driven bench for pwm_duty_calc plus hand sequences for
// mid-computation input change and mid-computation reset.
module tb_pwm_duty_calc;

  localparam int N_W = 43;
  localparam int NV  = 10;

`ifdef PWM_DUTY_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] h_cnt;
  logic [31:0] l_cnt;
  logic [9:0]  duty;
  logic [32:0] period;
  logic        duty_valid;
  logic        busy;
  logic        err;

  int tests   = 0;
  int fails   = 0;
  int strobes = 0;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic [9:0]  duty;
    logic [32:0] period;
    logic        err;
  } vec_t;

  vec_t vecs [NV];

  pwm_duty_calc dut (
    .clk        (clk),
    .reset      (reset),
    .h_cnt      (h_cnt),
    .l_cnt      (l_cnt),
    .duty       (duty),
    .period     (period),
    .duty_valid (duty_valid),
    .busy       (busy),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(negedge clk) if (duty_valid === 1'b1) strobes++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Counts edges until duty_valid is seen; -1 on timeout
  task automatic wait_valid(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (duty_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    h_cnt = v.h;
    l_cnt = v.l;
    @(posedge clk); #1;
    chk($sformatf("v%0d_busy_start", idx), 64'(busy), 64'd1);
    wait_valid(100, n);
    chk($sformatf("v%0d_latency", idx), 64'(n), v.err ? 64'd2 : 64'(N_W + 2));
    chk($sformatf("v%0d_duty", idx), 64'(duty), 64'(v.duty));
    chk($sformatf("v%0d_period", idx), 64'(period), 64'(v.period));
    chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.err));
    chk($sformatf("v%0d_busy_end", idx), 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_one_cycle", idx), 64'(duty_valid), 64'd0);
  endtask

  initial begin
    int n;
    int s;
    vecs[0] = '{32'd1250,   32'd1250,   10'd500,                   33'd2500,         1'b0};
    vecs[1] = '{32'd1,      32'd2,      10'd333,                   33'd3,            1'b0};
    vecs[2] = '{32'd2,      32'd1,      RND ? 10'd667 : 10'd666,   33'd3,            1'b0};
    vecs[3] = '{32'd0,      32'd7,      10'd0,                     33'd7,            1'b0};
    vecs[4] = '{32'd7,      32'd0,      10'd1000,                  33'd7,            1'b0};
    vecs[5] = '{32'd3,      32'd1,      10'd750,                   33'd4,            1'b0};
    vecs[6] = '{32'd0,      32'd0,      10'd0,                     33'd0,            1'b1};
    vecs[7] = '{32'd123456, 32'd654321, RND ? 10'd159 : 10'd158,   33'd777777,       1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'd1,   RND ? 10'd1000 : 10'd999,  33'h1_0000_0000,  1'b0};
    vecs[9] = '{32'd1000,   32'd3000,   10'd250,                   33'd4000,         1'b0};

    reset = 1'b0;
    h_cnt = '0;
    l_cnt = '0;
    #120;
    chk("rst_duty", 64'(duty), 64'd0);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_valid", 64'(duty_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_zero_no_strobe", 64'(strobes), 64'd0);
    chk("idle_zero_busy", 64'(busy), 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        s = strobes;
        repeat (60) @(posedge clk);
        #1;
        chk("held_no_restrobe", 64'(strobes), 64'(s));
        chk("held_busy", 64'(busy), 64'd0);
      end
    end

    // Input change during DIV: first result stays 5/5, newest pair follows
    @(negedge clk);
    h_cnt = 32'd5;
    l_cnt = 32'd5;
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    h_cnt = 32'd9;
    l_cnt = 32'd1;
    wait_valid(100, n);
    chk("mid_first_latency", 64'(n), 64'(N_W + 2 - 11));
    chk("mid_first_duty", 64'(duty), 64'd500);
    chk("mid_first_period", 64'(period), 64'd10);
    wait_valid(100, n);
    chk("mid_spacing", 64'(n), 64'(N_W + 3));
    chk("mid_second_duty", 64'(duty), 64'd900);
    chk("mid_second_period", 64'(period), 64'd10);

    // Reset mid-DIV aborts; held inputs are recomputed after release
    @(negedge clk);
    h_cnt = 32'd4;
    l_cnt = 32'd6;
    repeat (20) @(posedge clk);
    @(negedge clk);
    s = strobes;
    reset = 1'b0;
    #1;
    chk("rstmid_duty", 64'(duty), 64'd0);
    chk("rstmid_period", 64'(period), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_valid", 64'(duty_valid), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstmid_no_strobe", 64'(strobes), 64'(s));
    reset = 1'b1;
    wait_valid(100, n);
    chk("rstmid_recompute_latency", 64'(n), 64'(N_W + 3));
    chk("rstmid_recompute_duty", 64'(duty), 64'd400);
    chk("rstmid_recompute_period", 64'(period), 64'd10);
    chk("rstmid_recompute_err", 64'(err), 64'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("total_strobes", 64'(strobes), 64'(NV + 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
